// File: rtl/vm_keypad_scanner_pkg.sv
// Shared types and helpers for the vending-machine keypad scanner slice.
package vm_keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    PRESSED
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/vm_keypad_scanner_if.sv
// Row/column selection bus from the keypad scanner to the idle/selection stage.
interface vm_keypad_scanner_if;
  import vm_keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_out;
  logic [NUM_COLS-1:0] col_out;
  logic                key_valid;

  modport master (output row_out, output col_out, output key_valid);
  modport slave  (input  row_out, input  col_out, input  key_valid);
endinterface

// File: rtl/vm_keypad_scanner_row_sync.sv
// Two-flop synchronizer for asynchronous level inputs (keypad rows, coin sensors).
module vm_row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vm_keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce; drives the selection bus.
module vm_keypad_scanner
  import vm_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_sense,
  output logic [NUM_COLS-1:0] col_drive,
  vm_keypad_scanner_if.master sel
);

  localparam int unsigned TICK_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

  state_t              state;
  logic [1:0]          col_idx;
  logic [TICK_W-1:0]   tick_cnt;
  logic [CNT_W-1:0]    deb_cnt;
  logic [CNT_W-1:0]    rel_cnt;
  logic [NUM_ROWS-1:0] cand_row;
  logic [NUM_ROWS-1:0] row_s;
  logic                tick;

  vm_row_sync #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_sense),
    .q     (row_s)
  );

  assign tick      = (tick_cnt == TICK_LAST);
  assign col_drive = onehot4(col_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SCAN;
      col_idx       <= '0;
      tick_cnt      <= '0;
      deb_cnt       <= '0;
      rel_cnt       <= '0;
      cand_row      <= '0;
      sel.row_out   <= '0;
      sel.col_out   <= '0;
      sel.key_valid <= 1'b0;
    end else begin
      sel.key_valid <= 1'b0;
      tick_cnt      <= tick ? '0 : tick_cnt + 1'b1;

      if (tick) begin
        case (state)
          SCAN: begin
            // Multi-bit rows (ghosting or several keys) are skipped like an empty column.
            if ($onehot(row_s)) begin
              cand_row <= row_s;
              deb_cnt  <= CNT_W'(1);
              state    <= CONFIRM;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end

          CONFIRM: begin
            if (row_s == cand_row) begin
              deb_cnt <= deb_cnt + 1'b1;
              if (deb_cnt == CNT_LAST) begin
                sel.row_out   <= cand_row;
                sel.col_out   <= onehot4(col_idx);
                sel.key_valid <= 1'b1;
                rel_cnt       <= '0;
                state         <= PRESSED;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end

          PRESSED: begin
            if (row_s == '0) begin
              if (rel_cnt == CNT_LAST) begin
                sel.row_out <= '0;
                sel.col_out <= '0;
                rel_cnt     <= '0;
                col_idx     <= col_idx + 2'd1;
                state       <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + 1'b1;
              end
            end else begin
              rel_cnt <= '0;
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vm_keypad_scanner.sv
// Self-checking bench: a key-matrix model drives row_sense; a tick-level reference predicts outputs.
module tb_vm_keypad_scanner;
  import vm_keypad_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_sense;
  logic [3:0] col_drive;
  logic [3:0] keys [4];

  int compared   = 0;
  int mismatched = 0;

  vm_keypad_scanner_if sel_if ();

  vm_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_sense (row_sense),
    .col_drive (col_drive),
    .sel       (sel_if)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column strobe onto its row line.
  always_comb begin
    row_sense = '0;
    for (int c = 0; c < 4; c++)
      if (col_drive[c]) row_sense = row_sense | keys[c];
  end

  // Reference, one step per scan tick: column under test, candidate streak, held key.
  int         m_col, m_phase, m_streak, m_rel;
  logic [3:0] m_cand, m_row, m_colv;
  bit         m_kv;
  bit         kv_early, drive_moved;

  function automatic void model_reset();
    m_col = 0; m_phase = 0; m_streak = 0; m_rel = 0;
    m_cand = '0; m_row = '0; m_colv = '0; m_kv = 1'b0;
  endfunction

  function automatic void model_tick();
    logic [3:0] s;
    s = keys[m_col];
    m_kv = 1'b0;
    if (m_phase == 0) begin
      if ($countones(s) == 1) begin
        m_cand = s; m_streak = 1; m_phase = 1;
      end else m_col = (m_col + 1) % 4;
    end else if (m_phase == 1) begin
      if (s == m_cand) begin
        m_streak++;
        if (m_streak == DB) begin
          m_row = m_cand; m_colv = 4'(1 << m_col); m_kv = 1'b1; m_phase = 2; m_rel = 0;
        end
      end else begin
        m_phase = 0; m_col = (m_col + 1) % 4;
      end
    end else begin
      if (s == 4'b0) begin
        m_rel++;
        if (m_rel == DB) begin
          m_row = '0; m_colv = '0; m_phase = 0; m_col = (m_col + 1) % 4;
        end
      end else m_rel = 0;
    end
  endfunction

  function automatic logic [14:0] obs_vec();
    return {col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid, kv_early, drive_moved};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {4'(1 << m_col), m_row, m_colv, m_kv, 2'b00};
  endfunction

  // One scan period; ends 1 time unit after the tick edge. Keys change only here.
  task automatic tick_step();
    logic [3:0] prev;
    prev = col_drive;
    kv_early = 1'b0; drive_moved = 1'b0;
    for (int i = 0; i < SD; i++) begin
      @(posedge clk); #1;
      if (i < SD - 1) begin
        if (sel_if.key_valid !== 1'b0) kv_early = 1'b1;
        if (col_drive !== prev) drive_moved = 1'b1;
      end
    end
    model_tick();
  endtask

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_keys();
    for (int c = 0; c < 4; c++) keys[c] = '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) keys[c] = 4'($urandom_range(0, 15));
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid} !== 13'b0001_0000_0000_0) begin
        mismatched++;
        $display("FAIL reset cyc%0d: got drv=%b row=%b col=%b kv=%b want 0001/0000/0000/0",
                 i, col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid);
      end
    end
    clear_keys();
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle_scan();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_keys();
    compared++;
    if (col_drive !== seq[0]) begin
      mismatched++; $display("FAIL idle start: got %b want %b", col_drive, seq[0]);
    end
    for (int k = 1; k < 5; k++) begin
      tick_step();
      compared++;
      if ({col_drive, sel_if.key_valid, kv_early, drive_moved} !== {seq[k], 3'b000}) begin
        mismatched++;
        $display("FAIL idle step%0d: got drv=%b kv=%b early=%b moved=%b want %b/0/0/0",
                 k, col_drive, sel_if.key_valid, kv_early, drive_moved, seq[k]);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int n = 0;
    keys[1] = 4'b0100;
    while (m_phase != 2 && n < 20) begin
      tick_step(); n++;
      pulses += int'(sel_if.key_valid) + int'(kv_early);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL press tick%0d: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
    compared++;
    if ({sel_if.row_out, sel_if.col_out, sel_if.key_valid, col_drive} !== 13'b0100_0010_1_0010) begin
      mismatched++;
      $display("FAIL press code: got row=%b col=%b kv=%b drv=%b want 0100/0010/1/0010",
               sel_if.row_out, sel_if.col_out, sel_if.key_valid, col_drive);
    end
    for (int t = 0; t < 50; t++) begin
      tick_step();
      pulses += int'(sel_if.key_valid) + int'(kv_early);
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL hold tick%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
    end
    compared++;
    if (pulses !== 1) begin
      mismatched++; $display("FAIL press pulses: got %0d want 1", pulses);
    end
    clear_keys();
    for (int t = 0; t < DB; t++) tick_step();
    compared++;
    if (obs_vec() !== exp_vec()) begin
      mismatched++; $display("FAIL press release: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_bounce();
    int n = 0;
    clear_keys();
    while (m_col != 1 && n < 8) begin tick_step(); n++; end
    keys[1] = 4'b0100;
    tick_step();
    keys[1] = 4'b0000;
    tick_step();
    compared++;
    if ({col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid, kv_early} !== 14'b0100_0000_0000_00) begin
      mismatched++;
      $display("FAIL bounce: got drv=%b row=%b col=%b kv=%b early=%b want 0100/0000/0000/0/0",
               col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid, kv_early);
    end
    tick_step();
    compared++;
    if (obs_vec() !== exp_vec()) begin
      mismatched++; $display("FAIL bounce continue: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_release_glitch();
    int n = 0;
    int plan [6] = '{0, 0, 1, 0, 0, 0};
    keys[1] = 4'b0100;
    while (m_phase != 2 && n < 20) begin tick_step(); n++; end
    for (int k = 0; k < 6; k++) begin
      keys[1] = (plan[k] != 0) ? 4'b0100 : 4'b0000;
      tick_step();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL release step%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    compared++;
    if ({col_drive, sel_if.row_out, sel_if.col_out} !== 12'b0100_0000_0000) begin
      mismatched++;
      $display("FAIL release final: got drv=%b row=%b col=%b want 0100/0000/0000",
               col_drive, sel_if.row_out, sel_if.col_out);
    end
  endtask

  task automatic test_ghost();
    int n = 0;
    clear_keys();
    while (m_col != 0 && n < 8) begin tick_step(); n++; end
    keys[0] = 4'b0101;
    tick_step();
    keys[0] = 4'b0000;
    compared++;
    if ({col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid} !== 13'b0010_0000_0000_0) begin
      mismatched++;
      $display("FAIL ghost: got drv=%b row=%b col=%b kv=%b want 0010/0000/0000/0",
               col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid);
    end
  endtask

  task automatic test_reset_mid_confirm();
    int n = 0;
    keys[2] = 4'b1000;
    while (m_phase != 1 && n < 12) begin tick_step(); n++; end
    tick_step();
    // The next tick edge would register the key; reset lands on exactly that edge.
    repeat (SD - 1) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid} !== 13'b0001_0000_0000_0) begin
      mismatched++;
      $display("FAIL mid-reset: got drv=%b row=%b col=%b kv=%b want 0001/0000/0000/0",
               col_drive, sel_if.row_out, sel_if.col_out, sel_if.key_valid);
    end
    @(posedge clk);
    clear_keys();
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        int sel = $urandom_range(0, 9);
        clear_keys();
        if (sel >= 3 && sel <= 7)
          keys[$urandom_range(0, 3)] = 4'(1 << $urandom_range(0, 3));
        else if (sel >= 8)
          keys[$urandom_range(0, 3)] = 4'b1001;
      end
      tick_step();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++; $display("FAIL random tick%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
    end
    clear_keys();
  endtask

  initial begin
    reset = 1'b1;
    clear_keys();
    model_reset();
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_ghost();
    test_reset_mid_confirm();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
